// File: rtl/nco_chan_demux_if.sv
// Bus between the NCO side, the channel demultiplexer and its downstream consumer.
// Output side: a pair transfers on a rising edge where out_valid and out_ready are both high; while out_valid is high and out_ready low the pair and out_valid stay stable.
interface nco_chan_demux_if #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 8
);
  logic              clken;
  logic              in_valid;
  logic [DATA_W-1:0] fsin_i;
  logic [DATA_W-1:0] fcos_i;
  logic              chan_resync;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] sin_ch0_o;
  logic [DATA_W-1:0] cos_ch0_o;
  logic [DATA_W-1:0] sin_ch1_o;
  logic [DATA_W-1:0] cos_ch1_o;
  logic              ch_sel_o;
  logic              overrun_o;
  logic [CNT_W-1:0]  overrun_cnt_o;

  modport master (
    output clken, in_valid, fsin_i, fcos_i, chan_resync, out_ready,
    input  out_valid, sin_ch0_o, cos_ch0_o, sin_ch1_o, cos_ch1_o,
           ch_sel_o, overrun_o, overrun_cnt_o
  );

  modport slave (
    input  clken, in_valid, fsin_i, fcos_i, chan_resync, out_ready,
    output out_valid, sin_ch0_o, cos_ch0_o, sin_ch1_o, cos_ch1_o,
           ch_sel_o, overrun_o, overrun_cnt_o
  );
endinterface

// File: rtl/nco_chan_demux.sv
// Splits a time-multiplexed two-channel NCO sin/cos stream into ch0/ch1 pairs
// behind a single-entry valid/ready output register with sticky overrun counting.
module nco_chan_demux #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  nco_chan_demux_if.slave   bus
);

  typedef enum logic {S_CH0 = 1'b0, S_CH1 = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  state_t            base_state;
  logic              qual;
  logic              resync;
  logic              stage_ld;
  logic              pair_form;
  logic              out_load;
  logic              drop;
  logic              out_valid_q;
  logic [DATA_W-1:0] stg_sin;
  logic [DATA_W-1:0] stg_cos;
  logic [DATA_W-1:0] sin0_q;
  logic [DATA_W-1:0] cos0_q;
  logic [DATA_W-1:0] sin1_q;
  logic [DATA_W-1:0] cos1_q;
  logic              ovr_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_CH0;
    else          state <= state_nxt;
  end

  // A resync on the same cycle as a sample makes that sample ch0.
  always_comb begin
    qual       = bus.clken & bus.in_valid;
    resync     = bus.clken & bus.chan_resync;
    base_state = resync ? S_CH0 : state;
    state_nxt  = state;
    stage_ld   = 1'b0;
    pair_form  = 1'b0;
    if (qual) begin
      if (base_state == S_CH0) begin
        stage_ld  = 1'b1;
        state_nxt = S_CH1;
      end else begin
        pair_form = 1'b1;
        state_nxt = S_CH0;
      end
    end else if (resync) begin
      state_nxt = S_CH0;
    end
    out_load = pair_form & (~out_valid_q | bus.out_ready);
    drop     = pair_form & out_valid_q & ~bus.out_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_sin     <= '0;
      stg_cos     <= '0;
      sin0_q      <= '0;
      cos0_q      <= '0;
      sin1_q      <= '0;
      cos1_q      <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (stage_ld) begin
        stg_sin <= bus.fsin_i;
        stg_cos <= bus.fcos_i;
      end else if (resync) begin
        stg_sin <= '0;
        stg_cos <= '0;
      end
      if (out_load) begin
        sin0_q <= stg_sin;
        cos0_q <= stg_cos;
        sin1_q <= bus.fsin_i;
        cos1_q <= bus.fcos_i;
      end
      if (out_load)                       out_valid_q <= 1'b1;
      else if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      // Overrun state is sticky; the counter saturates at all-ones.
      if (drop) begin
        ovr_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.sin_ch0_o     = sin0_q;
  assign bus.cos_ch0_o     = cos0_q;
  assign bus.sin_ch1_o     = sin1_q;
  assign bus.cos_ch1_o     = cos1_q;
  assign bus.ch_sel_o      = (state == S_CH1);
  assign bus.overrun_o     = ovr_q;
  assign bus.overrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_nco_chan_demux.sv
// Self-checking bench for nco_chan_demux: directed scenarios plus randomized traffic
// against a queue-based reference model of the channel collector and output slot.
module tb_nco_chan_demux;
  localparam int DATA_W = 14;
  localparam int CNT_W  = 8;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  nco_chan_demux_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  nco_chan_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  wire [4*DATA_W-1:0] dut_pair = {bus.sin_ch0_o, bus.cos_ch0_o, bus.sin_ch1_o, bus.cos_ch1_o};

  // Reference model: samples collected since the last pair/resync, and the
  // output slot as a queue of at most one pair.
  logic [2*DATA_W-1:0] q_col[$];
  logic [4*DATA_W-1:0] exp_q[$];
  logic                m_ovr;
  logic [CNT_W-1:0]    m_cnt;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    q_col.delete();
    exp_q.delete();
    m_ovr = 1'b0;
    m_cnt = '0;
  endfunction

  function automatic void model_edge();
    bit                  qual = bus.clken && bus.in_valid;
    bit                  rs   = bus.clken && bus.chan_resync;
    logic [4*DATA_W-1:0] pr;
    if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
    if (rs) q_col.delete();
    if (qual) begin
      q_col.push_back({bus.fsin_i, bus.fcos_i});
      if (q_col.size() == 2) begin
        pr = {q_col[0], q_col[1]};
        q_col.delete();
        if (exp_q.size() == 0) exp_q.push_back(pr);
        else begin
          m_ovr = 1'b1;
          if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
      end
    end
  endfunction

  // driver tasks
  task automatic drive(input bit v, input bit ce, input bit rs, input bit rdy,
                       input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] c);
    bus.in_valid    = v;
    bus.clken       = ce;
    bus.chan_resync = rs;
    bus.out_ready   = rdy;
    bus.fsin_i      = s;
    bus.fcos_i      = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input bit v, input bit ce, input bit rs, input bit rdy,
                      input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] c);
    drive(v, ce, rs, rdy, s, c);
    tick();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4*DATA_W+CNT_W+2:0] got;
    drive(0, 0, 0, 0, '0, '0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    got = {bus.out_valid, bus.ch_sel_o, bus.overrun_o, bus.overrun_cnt_o, dut_pair};
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL reset_state: got %0h expected 0", got);
    end
    reset_n = 1'b1;
    step(0, 1, 0, 1, '0, '0);
    n_checks++;
    if (bus.ch_sel_o !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: ch_sel=%b out_valid=%b expected 0 0", bus.ch_sel_o, bus.out_valid);
    end
  endtask

  task automatic test_basic_pair();
    logic [4*DATA_W-1:0] exp;
    exp = {DATA_W'(100), DATA_W'(-100), DATA_W'(-8192), DATA_W'(8191)};
    step(1, 1, 0, 1, DATA_W'(100), DATA_W'(-100));
    n_checks++;
    if (bus.ch_sel_o !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_after_ch0: ch_sel=%b out_valid=%b expected 1 0", bus.ch_sel_o, bus.out_valid);
    end
    step(1, 1, 0, 1, DATA_W'(-8192), DATA_W'(8191));
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp) begin
      n_errors++;
      $display("FAIL basic_pair: valid=%b pair=%h expected 1 %h", bus.out_valid, dut_pair, exp);
    end
    step(0, 1, 0, 1, '0, '0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.ch_sel_o !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_drain: valid=%b ch_sel=%b expected 0 0", bus.out_valid, bus.ch_sel_o);
    end
  endtask

  task automatic test_overrun();
    logic [4*DATA_W-1:0] exp;
    exp = {DATA_W'(1), DATA_W'(2), DATA_W'(3), DATA_W'(4)};
    for (int p = 0; p < 3; p++) begin
      step(1, 1, 0, 0, DATA_W'(4*p+1), DATA_W'(4*p+2));
      step(1, 1, 0, 0, DATA_W'(4*p+3), DATA_W'(4*p+4));
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp) begin
      n_errors++;
      $display("FAIL overrun_hold: valid=%b pair=%h expected 1 %h", bus.out_valid, dut_pair, exp);
    end
    n_checks++;
    if (bus.overrun_o !== 1'b1 || bus.overrun_cnt_o !== 8'd2) begin
      n_errors++;
      $display("FAIL overrun_count: ovr=%b cnt=%0d expected 1 2", bus.overrun_o, bus.overrun_cnt_o);
    end
    n_checks++;
    if (bus.ch_sel_o !== 1'b0) begin
      n_errors++;
      $display("FAIL overrun_alternation: ch_sel=%b expected 0", bus.ch_sel_o);
    end
    step(0, 1, 0, 1, '0, '0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.overrun_cnt_o !== 8'd2) begin
      n_errors++;
      $display("FAIL overrun_drain: valid=%b cnt=%0d expected 0 2", bus.out_valid, bus.overrun_cnt_o);
    end
  endtask

  task automatic test_resync();
    logic [4*DATA_W-1:0] exp;
    exp = {DATA_W'(7), DATA_W'(8), DATA_W'(9), DATA_W'(10)};
    step(1, 1, 0, 1, DATA_W'(5), DATA_W'(6));
    step(0, 1, 1, 1, '0, '0);
    n_checks++;
    if (bus.ch_sel_o !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL resync_alone: ch_sel=%b valid=%b expected 0 0", bus.ch_sel_o, bus.out_valid);
    end
    step(1, 1, 0, 1, DATA_W'(7), DATA_W'(8));
    step(1, 1, 0, 1, DATA_W'(9), DATA_W'(10));
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp) begin
      n_errors++;
      $display("FAIL resync_pair: valid=%b pair=%h expected 1 %h", bus.out_valid, dut_pair, exp);
    end
    // resync coinciding with a sample, then a resync gated off by clken
    exp = {DATA_W'(13), DATA_W'(14), DATA_W'(15), DATA_W'(16)};
    step(1, 1, 0, 1, DATA_W'(11), DATA_W'(12));
    step(1, 1, 1, 1, DATA_W'(13), DATA_W'(14));
    step(0, 0, 1, 1, '0, '0);
    n_checks++;
    if (bus.ch_sel_o !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL resync_with_sample: ch_sel=%b valid=%b expected 1 0", bus.ch_sel_o, bus.out_valid);
    end
    step(1, 1, 0, 1, DATA_W'(15), DATA_W'(16));
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp) begin
      n_errors++;
      $display("FAIL resync_gated: valid=%b pair=%h expected 1 %h", bus.out_valid, dut_pair, exp);
    end
    step(0, 1, 0, 1, '0, '0);
  endtask

  task automatic test_clken();
    logic [4*DATA_W-1:0] exp;
    exp = {DATA_W'(21), DATA_W'(22), DATA_W'(25), DATA_W'(26)};
    step(1, 1, 0, 1, DATA_W'(21), DATA_W'(22));
    step(1, 0, 0, 1, DATA_W'(23), DATA_W'(24));
    n_checks++;
    if (bus.ch_sel_o !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL clken_gap: ch_sel=%b valid=%b expected 1 0", bus.ch_sel_o, bus.out_valid);
    end
    step(1, 1, 0, 1, DATA_W'(25), DATA_W'(26));
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp) begin
      n_errors++;
      $display("FAIL clken_pair: valid=%b pair=%h expected 1 %h", bus.out_valid, dut_pair, exp);
    end
    step(0, 1, 0, 1, '0, '0);
  endtask

  task automatic test_saturate();
    pulse_reset();
    for (int p = 0; p < 261; p++) begin
      step(1, 1, 0, 0, DATA_W'($urandom_range(0, 16383)), DATA_W'($urandom_range(0, 16383)));
      step(1, 1, 0, 0, DATA_W'($urandom_range(0, 16383)), DATA_W'($urandom_range(0, 16383)));
    end
    n_checks++;
    if (bus.overrun_cnt_o !== 8'hFF || bus.overrun_o !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate: cnt=%0d ovr=%b expected 255 1", bus.overrun_cnt_o, bus.overrun_o);
    end
    n_checks++;
    if (exp_q.size() != 1 || dut_pair !== exp_q[0]) begin
      n_errors++;
      $display("FAIL saturate_hold: pair=%h expected first pair of the run", dut_pair);
    end
  endtask

  task automatic test_mid_reset();
    logic [4*DATA_W+CNT_W+2:0] got;
    logic [4*DATA_W-1:0]       exp;
    exp = {DATA_W'(31), DATA_W'(32), DATA_W'(33), DATA_W'(34)};
    step(1, 1, 0, 0, DATA_W'(29), DATA_W'(30));
    reset_n = 1'b0;
    model_reset();
    #1;
    got = {bus.out_valid, bus.ch_sel_o, bus.overrun_o, bus.overrun_cnt_o, dut_pair};
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_async: got %0h expected 0", got);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 0, 1, DATA_W'(31), DATA_W'(32));
    step(1, 1, 0, 1, DATA_W'(33), DATA_W'(34));
    n_checks++;
    if (bus.out_valid !== 1'b1 || dut_pair !== exp || bus.overrun_cnt_o !== 8'd0) begin
      n_errors++;
      $display("FAIL mid_reset_pair: valid=%b pair=%h cnt=%0d expected 1 %h 0",
               bus.out_valid, dut_pair, bus.overrun_cnt_o, exp);
    end
    step(0, 1, 0, 1, '0, '0);
  endtask

  task automatic test_random();
    bit rdy;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0, rdy,
            DATA_W'($urandom_range(0, 16383)), DATA_W'($urandom_range(0, 16383)));
      if (bus.out_valid && rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL rand_handshake: got pair %h expected no valid pair", dut_pair);
        end else if (dut_pair !== exp_q[0]) begin
          n_errors++;
          $display("FAIL rand_handshake: got pair %h expected %h", dut_pair, exp_q[0]);
        end
      end
      tick();
      n_checks++;
      if (bus.out_valid !== (exp_q.size() != 0) || bus.ch_sel_o !== (q_col.size() != 0) ||
          bus.overrun_o !== m_ovr || bus.overrun_cnt_o !== m_cnt) begin
        n_errors++;
        $display("FAIL rand_state cycle %0d: valid=%b sel=%b ovr=%b cnt=%0d expected %b %b %b %0d", i,
                 bus.out_valid, bus.ch_sel_o, bus.overrun_o, bus.overrun_cnt_o,
                 exp_q.size() != 0, q_col.size() != 0, m_ovr, m_cnt);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    test_reset();
    test_basic_pair();
    test_overrun();
    test_resync();
    test_clken();
    test_saturate();
    test_mid_reset();
    pulse_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/nco_chan_demux.md
NCO_CHAN_DEMUX -- requirements
Module: nco_chan_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 14, meaning NCO sin/cos sample width in two's complement.
REQ-002 SHALL have parameter CNT_W, default 8, meaning overrun counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clken  input  1  clock enable; input sampling and resync act only when high.
REQ-006 SHALL have port in_valid  input  1  NCO out_valid; one time-multiplexed sample per cycle, channels alternating ch0, ch1.
REQ-007 SHALL have port fsin_i  input  DATA_W  NCO sine sample.
REQ-008 SHALL have port fcos_i  input  DATA_W  NCO cosine sample.
REQ-009 SHALL have port chan_resync  input  1  pulse; the sample on the same qualified cycle, or the next one, is ch0.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the pair when high with out_valid.
REQ-011 SHALL have port out_valid  output  1  a complete ch0/ch1 pair is held on the outputs.
REQ-012 SHALL have ports sin_ch0_o, cos_ch0_o, sin_ch1_o, cos_ch1_o  output  DATA_W each  demultiplexed pair.
REQ-013 SHALL have port ch_sel_o  output  1  channel expected for the next qualified sample (0 = ch0).
REQ-014 SHALL have port overrun_o  output  1  sticky flag: a pair was dropped.
REQ-015 SHALL have port overrun_cnt_o  output  CNT_W  number of dropped pairs, saturating.

Function
REQ-016 SHALL define a qualified sample as in_valid=1 and clken=1 at a rising edge.
REQ-017 SHALL use a two-state collector, S_CH0 and S_CH1; ch_sel_o=0 in S_CH0 and 1 in S_CH1.
REQ-018 SHALL, in S_CH0 on a qualified sample, store fsin_i/fcos_i in a ch0 staging register and go to S_CH1.
REQ-019 SHALL, in S_CH1 on a qualified sample, form the pair {staged ch0, current sample} and go to S_CH0.
REQ-020 SHALL hold state and all registers on any cycle with no qualified sample.
REQ-021 SHALL load a formed pair into the output registers when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-022 SHALL assert out_valid on the cycle after the ch1 sample edge, giving a latency of 1 clk from the ch1 sample.
REQ-023 SHALL keep the output registers and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear out_valid after an edge with out_valid=1 and out_ready=1, unless a new pair loads on that edge.
REQ-025 SHALL, when a pair forms while out_valid=1 and out_ready=0, discard the pair, set overrun_o, and increment overrun_cnt_o.
REQ-026 SHALL saturate overrun_cnt_o at all-ones.
REQ-027 SHALL keep the ch0/ch1 alternation unchanged after an overrun.
REQ-028 SHALL, on chan_resync=1 with clken=1, force the collector to S_CH0 and discard any staged ch0.
REQ-029 SHALL, if a qualified sample coincides with chan_resync, capture that sample as ch0 and go to S_CH1.
REQ-030 SHALL not let a resync affect the output registers, out_valid, or the overrun state.
REQ-031 SHALL ignore chan_resync when clken=0.
REQ-032 SHALL pass sample bits unchanged, with no sign or width conversion.
REQ-033 SHALL clear overrun_o and overrun_cnt_o only by reset.

Reset
REQ-034 SHALL, while reset_n=0, asynchronously force: state S_CH0, ch_sel_o=0, out_valid=0, all data outputs 0, staging 0, overrun_o=0, overrun_cnt_o=0.
REQ-035 SHALL, on reset mid-pair, lose any staged ch0; the first qualified sample after release is ch0.
REQ-036 SHALL release reset synchronously in effect, with no sample captured on the deassertion edge unless reset_n was already high at that edge.

Verification
REQ-037 SHALL cover this scenario: out_ready=1, samples (sin,cos) = (100,-100), then (-8192,8191) -> one cycle after the 2nd sample, out_valid=1, sin_ch0_o=100, cos_ch0_o=-100, sin_ch1_o=-8192, cos_ch1_o=8191.
REQ-038 SHALL cover this scenario: out_ready=0, 3 consecutive pairs -> pair 1 held; overrun_o=1, overrun_cnt_o=2; raising out_ready gives one handshake, then out_valid=0.
REQ-039 SHALL cover this scenario: ch0 sample (5,6), then chan_resync alone, then samples (7,8), (9,10) -> pair ch0=(7,8), ch1=(9,10); (5,6) never output.
REQ-040 SHALL cover this scenario: in_valid with clken toggling 1,0,1 over samples A, B, C -> B ignored; pair = (A, C).
REQ-041 SHALL cover this scenario: 260 dropped pairs with CNT_W=8 -> overrun_cnt_o=255.
REQ-042 SHALL cover this scenario: reset_n pulsed low after a ch0 sample -> all outputs 0 immediately; the next two samples form the pair.
